screen_line_buffer: RTL and testbench
=====================================

SCREEN_LINE_BUFFER -- requirements
Module: screen_line_buffer

Interface
REQ-001 SHALL have parameter PIX_W, default 12, pixel width in bits (4:4:4 RGB).
REQ-002 SHALL have parameter LINE_W, default 640, pixels per line (≥2); AW = clog2(LINE_W).
REQ-003 SHALL have parameter BLANK, default 0, PIX_W-bit pad/underrun pixel value.
REQ-004 SHALL have parameter CNT_W, default 16, width of lines_shown.
REQ-005 SHALL have port clk  in  1: single clock, all logic rising-edge.
REQ-006 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_valid  in  1: wr_data/wr_last valid.
REQ-008 SHALL have port wr_ready  out  1: buffer accepts a pixel this cycle.
REQ-009 SHALL have port wr_data  in  PIX_W: incoming pixel.
REQ-010 SHALL have port wr_last  in  1: final pixel of the current line.
REQ-011 SHALL have port rd_start  in  1: display requests scan-out of one line (pulse).
REQ-012 SHALL have port rd_valid  out  1: rd_data valid.
REQ-013 SHALL have port rd_data  out  PIX_W: outgoing pixel.
REQ-014 SHALL have port rd_last  out  1: high with the LINE_W-th output pixel.
REQ-015 SHALL have port underrun  out  1: one-cycle pulse on an underrun start.
REQ-016 SHALL have port underrun_cnt  out  8: saturating underrun count.
REQ-017 SHALL have port lines_shown  out  CNT_W: wrapping count of real (non-underrun) lines completed.

Function
REQ-018 SHALL hold two banks of LINE_W x PIX_W storage, each with a state EMPTY/FILLING/FULL/DRAINING and a stored length len (1..LINE_W).
REQ-019 SHALL keep write-bank pointer wb and read-bank pointer rb, both reset to 0.
REQ-020 SHALL drive wr_ready = 1 iff bank[wb] is EMPTY or FILLING; a transfer is wr_valid & wr_ready.
REQ-021 SHALL on a transfer write wr_data at wr_idx, move EMPTY->FILLING, and increment wr_idx.
REQ-022 SHALL close the bank (->FULL, len = wr_idx+1, wr_idx->0, wb toggles) on a transfer with wr_last=1 or with wr_idx = LINE_W-1, whichever comes first.
REQ-023 SHALL, when both banks are FULL/DRAINING, hold wr_ready low (back-pressure) without losing data.
REQ-024 SHALL, on rd_start with rd idle and bank[rb] FULL, set bank[rb] DRAINING and start a real scan.
REQ-025 SHALL, on rd_start with rd idle and bank[rb] not FULL, start an underrun scan: underrun pulses one cycle, underrun_cnt increments (saturating at 255), and bank states are unchanged.
REQ-026 SHALL ignore rd_start while a scan is in progress.
REQ-027 SHALL assert rd_valid exactly LINE_W consecutive cycles, the first one cycle after the accepted rd_start (registered read, latency 1).
REQ-028 SHALL output stored pixel i for i < len, and BLANK for len ≤ i < LINE_W or for every pixel of an underrun scan.
REQ-029 SHALL drive rd_last with the final (LINE_W-th) rd_valid cycle.
REQ-030 SHALL, at the end of a real scan, set the bank EMPTY, toggle rb, and increment lines_shown (wrapping).
REQ-031 SHALL evaluate rd_start against bank state before the same-cycle write update, so a bank closing in the same cycle as rd_start yields an underrun.
REQ-032 SHALL allow writes into bank[wb] concurrently with draining bank[rb] when wb ≠ rb.
REQ-033 SHALL, when a bank is released (DRAINING->EMPTY) in the same cycle the writer is stalled on it, raise wr_ready on the following cycle.

Reset
REQ-034 SHALL on rst force both banks EMPTY, wb=rb=0, wr_idx=0, scan idle, and all outputs to 0 except wr_ready=1, regardless of any operation in progress; memory contents need not be cleared.

Verification (LINE_W=8, PIX_W=12, BLANK=0)
REQ-035 SHALL cover: write 8 pixels 0x101..0x108 then rd_start -> rd_valid 8 cycles starting 1 cycle later, data 0x101..0x108, rd_last on 0x108, lines_shown=1.
REQ-036 SHALL cover: write 3 pixels 0xA01..0xA03 with wr_last on the 3rd, rd_start -> output 0xA01,0xA02,0xA03 then 5 x 0x000.
REQ-037 SHALL cover: rd_start with no line written -> underrun pulse, 8 x 0x000, underrun_cnt=1, lines_shown unchanged.
REQ-038 SHALL cover: write 3 full lines without reads -> wr_ready low after 16 transfers; one rd_start scan completes -> wr_ready high and the third line is accepted intact.
REQ-039 SHALL cover: rst asserted asynchronously mid-scan (output pixel 4) -> rd_valid, rd_last, and counters 0 immediately, and wr_ready=1.
REQ-040 SHALL cover: 256+ consecutive underruns -> underrun_cnt holds at 255.

Source files
------------

// File: rtl/screen_line_buffer.sv
// screen_line_buffer: ping-pong line buffer sitting between a pixel producer
// and a display scan-out engine.
//   clk, rst             : single rising-edge clock, async active-high reset
//   wr_valid/wr_ready    : write handshake; wr_data pixel, wr_last closes a line
//   rd_start             : pulse requesting scan-out of one LINE_W-pixel line
//   rd_valid/rd_data     : scanned pixels, one cycle after the accepted rd_start
//   rd_last              : marks the LINE_W-th output pixel
//   underrun             : one-cycle pulse when a scan starts with no full line
//   underrun_cnt         : saturating count of underrun scans
//   lines_shown          : wrapping count of real lines fully scanned out
module screen_line_buffer #(
  parameter int unsigned     PIX_W  = 12,
  parameter int unsigned     LINE_W = 640,
  parameter logic [PIX_W-1:0] BLANK = '0,
  parameter int unsigned     CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_last,
  input  logic             rd_start,
  output logic             rd_valid,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_last,
  output logic             underrun,
  output logic [7:0]       underrun_cnt,
  output logic [CNT_W-1:0] lines_shown
);

  localparam int unsigned AW = $clog2(LINE_W);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  bank_st_e         st_q [2];
  bank_st_e         st_n [2];
  logic [LW-1:0]    len_q [2];
  logic [LW-1:0]    len_n [2];
  logic             wb_q, wb_n, rb_q, rb_n;
  logic [AW-1:0]    wr_idx_q, wr_idx_n;
  logic [AW-1:0]    rd_idx_q, rd_idx_n;
  logic             busy_q, busy_n;
  logic             real_q, real_n;
  logic [PIX_W-1:0] mem [2][LINE_W];

  logic             xfer, closing, accept, emit, scan_end, px_real;
  logic [AW-1:0]    px_idx;

  logic             wr_ready_n, rd_valid_n, rd_last_n, underrun_n;
  logic [PIX_W-1:0] rd_data_n;
  logic [7:0]       ucnt_n;
  logic [CNT_W-1:0] lines_n;

  // Handshake and scan-step decode
  assign xfer     = wr_valid & wr_ready;
  assign closing  = wr_last | (wr_idx_q == AW'(LINE_W - 1));
  assign accept   = rd_start & ~busy_q;
  assign emit     = accept | busy_q;
  assign px_idx   = accept ? '0 : rd_idx_q;
  assign scan_end = (px_idx == AW'(LINE_W - 1));
  // A scan is real only if the bank was FULL when rd_start was sampled
  assign px_real  = accept ? (st_q[rb_q] == FULL) : real_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]      <= EMPTY;
      st_q[1]      <= EMPTY;
      len_q[0]     <= '0;
      len_q[1]     <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      busy_q       <= 1'b0;
      real_q       <= 1'b0;
      wr_ready     <= 1'b1;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_last      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      lines_shown  <= '0;
    end else begin
      st_q[0]      <= st_n[0];
      st_q[1]      <= st_n[1];
      len_q[0]     <= len_n[0];
      len_q[1]     <= len_n[1];
      wb_q         <= wb_n;
      rb_q         <= rb_n;
      wr_idx_q     <= wr_idx_n;
      rd_idx_q     <= rd_idx_n;
      busy_q       <= busy_n;
      real_q       <= real_n;
      wr_ready     <= wr_ready_n;
      rd_valid     <= rd_valid_n;
      rd_data      <= rd_data_n;
      rd_last      <= rd_last_n;
      underrun     <= underrun_n;
      underrun_cnt <= ucnt_n;
      lines_shown  <= lines_n;
    end
  end

  // Pixel storage (contents survive reset)
  always_ff @(posedge clk) begin
    if (xfer) mem[wb_q][wr_idx_q] <= wr_data;
  end

  // Next-state: read side decides on current bank state, then write side
  always_comb begin
    st_n[0]  = st_q[0];
    st_n[1]  = st_q[1];
    len_n[0] = len_q[0];
    len_n[1] = len_q[1];
    wb_n     = wb_q;
    rb_n     = rb_q;
    wr_idx_n = wr_idx_q;
    rd_idx_n = rd_idx_q;
    busy_n   = busy_q;
    real_n   = real_q;

    if (accept) begin
      real_n = (st_q[rb_q] == FULL);
      if (st_q[rb_q] == FULL) st_n[rb_q] = DRAINING;
    end

    if (emit) begin
      if (scan_end) begin
        busy_n = 1'b0;
        if (real_q) begin
          st_n[rb_q] = EMPTY;
          rb_n       = ~rb_q;
        end
      end else begin
        busy_n   = 1'b1;
        rd_idx_n = px_idx + AW'(1);
      end
    end

    // Writer only ever touches an EMPTY/FILLING bank, never the draining one
    if (xfer) begin
      if (closing) begin
        st_n[wb_q]  = FULL;
        len_n[wb_q] = LW'(wr_idx_q) + LW'(1);
        wr_idx_n    = '0;
        wb_n        = ~wb_q;
      end else begin
        st_n[wb_q]  = FILLING;
        wr_idx_n    = wr_idx_q + AW'(1);
      end
    end
  end

  // Next registered outputs
  always_comb begin
    wr_ready_n = (st_n[wb_n] == EMPTY) || (st_n[wb_n] == FILLING);
    rd_valid_n = emit;
    rd_last_n  = emit & scan_end;
    underrun_n = accept & (st_q[rb_q] != FULL);
    rd_data_n  = BLANK;
    if (emit && px_real && ({1'b0, px_idx} < len_q[rb_q]))
      rd_data_n = mem[rb_q][px_idx];
    ucnt_n = underrun_cnt;
    if (underrun_n && (underrun_cnt != 8'hFF)) ucnt_n = underrun_cnt + 8'd1;
    lines_n = lines_shown;
    if (emit && scan_end && real_q) lines_n = lines_shown + CNT_W'(1);
  end

endmodule

// File: tb/tb_screen_line_buffer.sv
// Scoreboard bench for screen_line_buffer with LINE_W=8, PIX_W=12, BLANK=0.
// Stimulus pushes expected scan pixels; a negedge monitor pops and compares.
module tb_screen_line_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready, wr_last, rd_start;
  logic        rd_valid, rd_last, underrun;
  logic [11:0] wr_data, rd_data;
  logic [7:0]  underrun_cnt;
  logic [15:0] lines_shown;

  typedef struct packed {
    logic [11:0] data;
    logic        last;
    logic        ur;
  } exp_t;
  typedef logic [11:0] line_t [8];

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  screen_line_buffer #(.PIX_W(12), .LINE_W(8), .BLANK(12'h000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .lines_shown(lines_shown)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented pixel against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (sb.size() == 0) begin
          check("rd_unexpected_valid", rd_valid, 0);
        end else begin
          e = sb.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_last", rd_last, e.last);
          check("underrun_pulse", underrun, e.ur);
        end
      end else if (underrun) begin
        check("underrun_without_valid", underrun, 0);
      end
    end
  end

  task automatic push_scan(input line_t px, input int n, input bit ur);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = (!ur && i < n) ? px[i] : 12'h000;
      e.last = (i == 7);
      e.ur   = ur && (i == 0);
      sb.push_back(e);
    end
  endtask

  task automatic start_scan(input line_t px, input int n, input bit ur);
    push_scan(px, n, ur);
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    check("scan_latency", rd_valid, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout_left", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic write_px(input logic [11:0] d, input bit last);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    while (!wr_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wr_ready) check("wr_accept_timeout", wr_ready, 1);
    else begin
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic write_line(input line_t px, input int n, input bit use_last);
    for (int i = 0; i < n; i++) write_px(px[i], use_last && (i == n - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t l1, l2, l3, la, lb, lc, ld, zero;
    for (int i = 0; i < 8; i++) begin
      l1[i]   = 12'h101 + 12'(i);
      la[i]   = 12'hA01 + 12'(i);
      l2[i]   = 12'h201 + 12'(i);
      l3[i]   = 12'h301 + 12'(i);
      lb[i]   = 12'h401 + 12'(i);
      lc[i]   = 12'h501 + 12'(i);
      ld[i]   = 12'h601 + 12'(i);
      zero[i] = 12'h000;
    end
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; rd_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_underrun_cnt", underrun_cnt, 0);
    check("rst_lines_shown", lines_shown, 0);

    // Full line closed by the LINE_W-th pixel
    write_line(l1, 8, 1'b0);
    start_scan(l1, 8, 1'b0);
    wait_drain();
    check("full_line_lines_shown", lines_shown, 1);

    // Short line padded with BLANK
    write_line(la, 3, 1'b1);
    start_scan(la, 3, 1'b0);
    wait_drain();
    check("short_line_lines_shown", lines_shown, 2);

    // Underrun with nothing written
    start_scan(zero, 0, 1'b1);
    wait_drain();
    check("underrun_cnt_1", underrun_cnt, 1);
    check("underrun_lines_unchanged", lines_shown, 2);

    // Back-pressure after two full banks, then concurrent write/drain
    write_line(l2, 8, 1'b0);
    write_line(l3, 8, 1'b0);
    check("backpressure_ready_low", wr_ready, 0);
    start_scan(l2, 8, 1'b0);
    check("backpressure_during_scan", wr_ready, 0);
    wait_drain();
    check("ready_after_release", wr_ready, 1);
    start_scan(l3, 8, 1'b0);
    write_line(lb, 8, 1'b0);
    wait_drain();
    start_scan(lb, 8, 1'b0);
    wait_drain();
    check("three_lines_lines_shown", lines_shown, 5);

    // Bank closing in the same cycle as rd_start yields an underrun
    write_line(lc, 7, 1'b0);
    check("close_race_ready", wr_ready, 1);
    wr_valid = 1'b1; wr_data = lc[7]; wr_last = 1'b0;
    push_scan(zero, 0, 1'b1);
    rd_start = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_start = 1'b0;
    check("close_race_latency", rd_valid, 1);
    wait_drain();
    check("close_race_underrun_cnt", underrun_cnt, 2);
    start_scan(lc, 8, 1'b0);
    wait_drain();
    check("close_race_lines_shown", lines_shown, 6);

    // Underrun counter saturation
    for (int k = 0; k < 260; k++) begin
      start_scan(zero, 0, 1'b1);
      wait_drain();
    end
    check("underrun_cnt_saturated", underrun_cnt, 255);
    check("saturation_lines_unchanged", lines_shown, 6);

    // Asynchronous reset while pixel 4 is on the output
    write_line(ld, 8, 1'b0);
    start_scan(ld, 8, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_pixel4_valid", rd_valid, 1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst_rd_valid", rd_valid, 0);
    check("async_rst_rd_last", rd_last, 0);
    check("async_rst_rd_data", rd_data, 0);
    check("async_rst_underrun_cnt", underrun_cnt, 0);
    check("async_rst_lines_shown", lines_shown, 0);
    check("async_rst_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", rd_valid, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
